regfile_dual: RTL

//   Architectural register state for the single-cycle datapath: 32 integer and 32 FP registers.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_bank.sv | 73 +++++++
 rtl/regfile_dual.sv | 87 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the dual integer/FP register file.
// BYPASS_EN enables same-cycle write-through forwarding.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [0:DATA_W-1] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Odd partner of an even index, used for the low word of a double.
    function automatic reg_idx_t pair_idx(input reg_idx_t r);
        return {r[ADDR_W-1:1], 1'b1};
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// One register bank: 2 async read ports, 2 write ports, async clear.
// BYPASS_EN forwards write data to matching read ports.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] rb_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [0:DATA_W-1] wd0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [0:DATA_W-1] wd1_i,
    output logic [0:DATA_W-1] da_o,
    output logic [0:DATA_W-1] db_o
);

    word_t mem_q [NREGS];
    word_t mem_d [NREGS];
    logic  wr0;
    logic  wr1;

    assign wr0 = we0_i && !(ZERO_R0 && (wa0_i == REG_ZERO));
    assign wr1 = we1_i && !(ZERO_R0 && (wa1_i == REG_ZERO));

    always_comb begin
        mem_d = mem_q;
        if (wr0) mem_d[wa0_i] = wd0_i;
        if (wr1) mem_d[wa1_i] = wd1_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Forwarding is masked during reset so outputs read 0 while rst is held.
    always_comb begin
        da_o = mem_q[ra_i];
        if (ZERO_R0 && (ra_i == REG_ZERO)) begin
            da_o = '0;
        end
`ifdef BYPASS_EN
        else if (!rst && wr1 && (wa1_i == ra_i)) begin
            da_o = wd1_i;
        end else if (!rst && wr0 && (wa0_i == ra_i)) begin
            da_o = wd0_i;
        end
`endif
    end

    always_comb begin
        db_o = mem_q[rb_i];
        if (ZERO_R0 && (rb_i == REG_ZERO)) begin
            db_o = '0;
        end
`ifdef BYPASS_EN
        else if (!rst && wr1 && (wa1_i == rb_i)) begin
            db_o = wd1_i;
        end else if (!rst && wr0 && (wa0_i == rb_i)) begin
            db_o = wd0_i;
        end
`endif
    end

endmodule

// File: rtl/regfile_dual.sv
// Integer + FP architectural register file with FP double writes.
// Define BYPASS_EN for same-cycle write-through forwarding.
module regfile_dual
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              regWrite,
    input  logic              fpRegWrite,
    input  logic              fpDouble,
    input  logic [0:DATA_W-1] busW,
    input  logic [0:DATA_W-1] fbusW,
    input  logic [0:DATA_W-1] fbusW2,
    output logic [0:DATA_W-1] busA,
    output logic [0:DATA_W-1] busB,
    output logic [0:DATA_W-1] fbusA,
    output logic [0:DATA_W-1] fbusB,
    output logic              oddDblErr
);

    logic     dbl;
    logic     dbl_odd;
    logic     fp_we0;
    logic     fp_we1;
    reg_idx_t rd_pair;
    logic     err_q;
    logic     err_d;

    // An odd-index double is rejected outright: neither slot is written.
    assign dbl     = fpRegWrite & fpDouble;
    assign dbl_odd = dbl & rd[0];
    assign fp_we0  = fpRegWrite & ~dbl_odd;
    assign fp_we1  = dbl & ~rd[0];
    assign rd_pair = pair_idx(rd);

    always_comb begin
        err_d = err_q | dbl_odd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign oddDblErr = err_q;

    regfile_bank #(
        .ZERO_R0 (1'b1)
    ) u_int_bank (
        .clk   (clk),
        .rst   (rst),
        .ra_i  (rs),
        .rb_i  (rt),
        .we0_i (regWrite),
        .wa0_i (rd),
        .wd0_i (busW),
        .we1_i (1'b0),
        .wa1_i (REG_ZERO),
        .wd1_i ('0),
        .da_o  (busA),
        .db_o  (busB)
    );

    regfile_bank #(
        .ZERO_R0 (1'b0)
    ) u_fp_bank (
        .clk   (clk),
        .rst   (rst),
        .ra_i  (rs),
        .rb_i  (rt),
        .we0_i (fp_we0),
        .wa0_i (rd),
        .wd0_i (fbusW),
        .we1_i (fp_we1),
        .wa1_i (rd_pair),
        .wd1_i (fbusW2),
        .da_o  (fbusA),
        .db_o  (fbusB)
    );

endmodule
